// File: rtl/ontransit_arb.sv
// Round-robin scheduler sharing one on-transit handshake engine among N_REQ requesters.
// Drives the engine's do line for a latched burst length, checks the s/g responses,
// and reports completion and protocol errors back to the granted requester.
module ontransit_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned TMO   = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   len,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     do_o,
    input  logic                     g_i,
    input  logic                     s_i,
    output logic                     busy,
    output logic                     err_tmo,
    output logic                     err_cnt,
    input  logic                     err_clr
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMO_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_WAIT_G = 2'd2,
        S_COOL   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               do_q, do_d;
    logic               busy_q, busy_d;
    logic               err_tmo_q, err_tmo_d;
    logic               err_cnt_q, err_cnt_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   dcnt_q, dcnt_d;
    logic [LEN_W-1:0]   scnt_q, scnt_d;
    logic [TMO_W-1:0]   tcnt_q, tcnt_d;

    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic [LEN_W-1:0]   win_len;
    logic [LEN_W-1:0]   s_next;
    logic               set_cnt;
    logic               set_tmo;

    // Round-robin search: first set req bit upward from rr_q, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_len = '0;
        cand    = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = PTR_W'((32'(rr_q) + 32'(k)) % N_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
                win_len = len[32'(cand)*LEN_W +: LEN_W];
            end
        end
    end

    // Burst sequencing FSM with s counting, timeout and protocol checks.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        do_d    = 1'b0;
        rr_d    = rr_q;
        len_d   = len_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        tcnt_d  = tcnt_q;
        set_cnt = 1'b0;
        set_tmo = 1'b0;

        // Saturating count of s pulses including the current cycle.
        s_next = scnt_q;
        if (s_i && (scnt_q != '1)) begin
            s_next = scnt_q + LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (g_i || s_i) begin
                    set_cnt = 1'b1;
                end
                if (win_vld) begin
                    state_d = S_DRIVE;
                    gnt_d   = N_REQ'(1) << win_idx;
                    len_d   = (win_len == '0) ? LEN_W'(1) : win_len;
                    rr_d    = PTR_W'((32'(win_idx) + 32'd1) % N_REQ);
                    dcnt_d  = '0;
                    scnt_d  = '0;
                    tcnt_d  = '0;
                    do_d    = 1'b1;
                end
            end
            S_DRIVE: begin
                if (g_i) begin
                    set_cnt = 1'b1;
                end
                scnt_d = s_next;
                if (dcnt_q == (len_q - LEN_W'(1))) begin
                    state_d = S_WAIT_G;
                    tcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + LEN_W'(1);
                    do_d   = 1'b1;
                end
            end
            S_WAIT_G: begin
                scnt_d = s_next;
                if (g_i) begin
                    if (s_next != (len_q - LEN_W'(1))) begin
                        set_cnt = 1'b1;
                    end
                    state_d = S_COOL;
                    done_d  = gnt_q;
                end else if (tcnt_q == TMO_W'(TMO - 1)) begin
                    set_tmo = 1'b1;
                    state_d = S_COOL;
                    done_d  = gnt_q;
                end else begin
                    tcnt_d = tcnt_q + TMO_W'(1);
                end
            end
            S_COOL: begin
                if (g_i || s_i) begin
                    set_cnt = 1'b1;
                end
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        err_tmo_d = (err_tmo_q & ~err_clr) | set_tmo;
        err_cnt_d = (err_cnt_q & ~err_clr) | set_cnt;
    end

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            do_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_tmo_q <= 1'b0;
            err_cnt_q <= 1'b0;
            rr_q      <= '0;
            len_q     <= '0;
            dcnt_q    <= '0;
            scnt_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            do_q      <= do_d;
            busy_q    <= busy_d;
            err_tmo_q <= err_tmo_d;
            err_cnt_q <= err_cnt_d;
            rr_q      <= rr_d;
            len_q     <= len_d;
            dcnt_q    <= dcnt_d;
            scnt_q    <= scnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign do_o    = do_q;
    assign busy    = busy_q;
    assign err_tmo = err_tmo_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ontransit_arb.sv
// Directed bench for ontransit_arb with a behavioural on-transit engine attached.
module tb_ontransit_arb;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned LEN_W = 8;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] len;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   do_o;
    logic                   g_i;
    logic                   s_i;
    logic                   busy;
    logic                   err_tmo;
    logic                   err_cnt;
    logic                   err_clr;

    logic                   sup_g;
    logic                   inj_g;
    logic                   inj_s;

    int n_chk;
    int n_fail;

    ontransit_arb #(.N_REQ(N_REQ), .LEN_W(LEN_W), .TMO(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .do_o    (do_o),
        .g_i     (g_i),
        .s_i     (s_i),
        .busy    (busy),
        .err_tmo (err_tmo),
        .err_cnt (err_cnt),
        .err_clr (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: IDLE -> RUN on do; RUN stays with s while do, exits with g; LAST -> IDLE.
    typedef enum logic [1:0] {E_IDLE, E_RUN, E_LAST} eng_e;
    eng_e eng;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng <= E_IDLE;
        end else begin
            case (eng)
                E_IDLE:  if (do_o) eng <= E_RUN;
                E_RUN:   if (!do_o) eng <= E_LAST;
                default: eng <= E_IDLE;
            endcase
        end
    end

    assign s_i = ((eng == E_RUN) && do_o) || inj_s;
    assign g_i = ((eng == E_RUN) && !do_o && !sup_g) || inj_g;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        len     = '0;
        err_clr = 1'b0;
        sup_g   = 1'b0;
        inj_g   = 1'b0;
        inj_s   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [3:0] eg;
        n_chk  = 0;
        n_fail = 0;

        do_reset();
        check("rst_gnt",     32'(gnt),     32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_do",      32'(do_o),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_err_tmo", 32'(err_tmo), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Nominal L=3 burst for requester 0.
        len[7:0] = 8'd3;
        req      = 4'b0001;
        tick();
        for (int c = 0; c < 6; c++) begin
            check("t1_do",   32'(do_o), (c < 3) ? 32'd1 : 32'd0);
            check("t1_done", 32'(done), (c == 4) ? 32'd1 : 32'd0);
            check("t1_gnt",  32'(gnt),  (c < 5) ? 32'd1 : 32'd0);
            check("t1_busy", 32'(busy), (c < 5) ? 32'd1 : 32'd0);
            if (c == 4) req = 4'b0000;
            tick();
        end
        check("t1_err_cnt", 32'(err_cnt), 32'd0);
        check("t1_err_tmo", 32'(err_tmo), 32'd0);

        // All four requesting with len=1 from rr=0: grants rotate 0,1,2,3,0.
        do_reset();
        len = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        tick();
        for (int b = 0; b < 5; b++) begin
            eg = 4'(4'b0001 << (b % 4));
            check("t2_gnt",   32'(gnt),  32'(eg));
            check("t2_do_on", 32'(do_o), 32'd1);
            tick();
            check("t2_do_off", 32'(do_o), 32'd0);
            check("t2_gnt_w",  32'(gnt),  32'(eg));
            tick();
            check("t2_done", 32'(done), 32'(eg));
            if (b == 4) req = 4'b0000;
            tick();
            check("t2_gnt_idle", 32'(gnt),  32'd0);
            check("t2_busy_idle", 32'(busy), 32'd0);
            tick();
        end
        check("t2_err_cnt", 32'(err_cnt), 32'd0);

        // len=0 behaves as len=1.
        len[7:0] = 8'd0;
        req      = 4'b0001;
        tick();
        check("t3_gnt", 32'(gnt),  32'd1);
        check("t3_do",  32'(do_o), 32'd1);
        tick();
        check("t3_do_off", 32'(do_o), 32'd0);
        check("t3_busy",   32'(busy), 32'd1);
        tick();
        check("t3_done", 32'(done), 32'd1);
        req = 4'b0000;
        tick();
        check("t3_idle",    32'(busy),    32'd0);
        check("t3_err_cnt", 32'(err_cnt), 32'd0);

        // Suppressed g: 15 WAIT_G cycles, then timeout with done.
        len[7:0] = 8'd2;
        sup_g    = 1'b1;
        req      = 4'b0001;
        tick();
        repeat (16) tick();
        check("t4_pre_done", 32'(done),    32'd0);
        check("t4_pre_tmo",  32'(err_tmo), 32'd0);
        check("t4_pre_busy", 32'(busy),    32'd1);
        tick();
        check("t4_done",    32'(done),    32'd1);
        check("t4_err_tmo", 32'(err_tmo), 32'd1);
        req   = 4'b0000;
        sup_g = 1'b0;
        tick();
        check("t4_idle",       32'(busy),    32'd0);
        check("t4_tmo_sticky", 32'(err_tmo), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_tmo_clr", 32'(err_tmo), 32'd0);
        check("t4_cnt_clean", 32'(err_cnt), 32'd0);

        // Extra s pulse in a len=4 burst gives a count mismatch at g.
        len[7:0] = 8'd4;
        req      = 4'b0001;
        tick();
        inj_s = 1'b1;
        tick();
        inj_s = 1'b0;
        repeat (3) tick();
        check("t5_g_cyc_cnt", 32'(err_cnt), 32'd0);
        check("t5_g_cyc_do",  32'(do_o),    32'd0);
        tick();
        check("t5_done",    32'(done),    32'd1);
        check("t5_err_cnt", 32'(err_cnt), 32'd1);
        req = 4'b0000;
        tick();
        check("t5_idle", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_cnt_clr", 32'(err_cnt), 32'd0);
        inj_g = 1'b1;
        tick();
        inj_g = 1'b0;
        check("t5_spur_g",     32'(err_cnt), 32'd1);
        check("t5_spur_busy",  32'(busy),    32'd0);
        check("t5_spur_gnt",   32'(gnt),     32'd0);
        inj_g   = 1'b1;
        err_clr = 1'b1;
        tick();
        inj_g = 1'b0;
        check("t5_set_wins", 32'(err_cnt), 32'd1);
        tick();
        err_clr = 1'b0;
        check("t5_clr_only", 32'(err_cnt), 32'd0);

        // Reset mid-burst aborts asynchronously; rr restarts at 0.
        len[23:16] = 8'd200;
        req        = 4'b0100;
        tick();
        check("t6_gnt", 32'(gnt), 32'b0100);
        repeat (5) tick();
        check("t6_do_mid",   32'(do_o), 32'd1);
        check("t6_busy_mid", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_do",   32'(do_o), 32'd0);
        check("t6_async_gnt",  32'(gnt),  32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_done", 32'(done), 32'd0);
        req        = 4'b1010;
        len[15:8]  = 8'd2;
        len[31:24] = 8'd2;
        tick();
        tick();
        check("t6_rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("t6_regnt",    32'(gnt),  32'b0010);
        check("t6_regnt_do", 32'(do_o), 32'd1);
        tick();
        tick();
        tick();
        check("t6_done",    32'(done),    32'b0010);
        check("t6_err_cnt", 32'(err_cnt), 32'd0);
        check("t6_err_tmo", 32'(err_tmo), 32'd0);
        req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
